// File: rtl/pulse_meter_pkg.sv
// Shared types and default constants for the pulse period meter and its helpers.
package pulse_meter_pkg;

    localparam int PM_CNT_W = 24;
    localparam logic [PM_CNT_W-1:0] PM_TIMEOUT = 24'd12_000_000;

    typedef enum logic {
        WAIT_FIRST,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous single-bit input, followed by a
// registered rising-edge detector producing a one-cycle pulse per rising edge.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Flops clear to 0, so an input already high when reset releases yields one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~dly_q;
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive rising edges of pulse_in, publishing each
// period with a one-cycle strobe and flagging missing pulses with a sticky timeout.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int               CNT_W       = PM_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(PM_TIMEOUT),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    if ((TIMEOUT < CNT_W'(2)) || (SYNC_STAGES < 2)) begin : g_param_err
        $error("pulse_period_meter: TIMEOUT must be >= 2 and SYNC_STAGES >= 2");
    end

    logic             rise;
    meter_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] period_n;
    logic             period_vld_n, locked_n, timeout_n;

    sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk (clk),
        .rst (rst),
        .din (pulse_in),
        .rise(rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_FIRST;
            cnt        <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            period     <= period_n;
            period_vld <= period_vld_n;
            locked     <= locked_n;
            timeout    <= timeout_n;
        end
    end

    // An edge arriving in the same cycle cnt reaches TIMEOUT is a valid period.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        period_n     = period;
        period_vld_n = 1'b0;
        locked_n     = locked;
        timeout_n    = timeout;
        case (state)
            WAIT_FIRST: begin
                cnt_n = '0;
                if (rise) begin
                    cnt_n     = CNT_W'(1);
                    timeout_n = 1'b0;
                    state_n   = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_n     = cnt;
                    period_vld_n = 1'b1;
                    locked_n     = 1'b1;
                    timeout_n    = 1'b0;
                    cnt_n        = CNT_W'(1);
                end else if (cnt == TIMEOUT) begin
                    timeout_n = 1'b1;
                    locked_n  = 1'b0;
                    cnt_n     = '0;
                    state_n   = WAIT_FIRST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_FIRST;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter with TIMEOUT=100, SYNC_STAGES=2.
module tb_pulse_period_meter;

    localparam int CNT_W = 24;
    localparam int TMO   = 100;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pulse_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             timeout;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_q[$];
    int               exp_t_q[$];
    logic [CNT_W-1:0] mon_p;
    int               mon_t;

    typedef struct {
        int width;
        int gap;
        bit exp_vld;
        int exp_period;
    } vec_t;

    vec_t train_v[5];
    vec_t min_v[7];

    pulse_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (24'd100),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .period    (period),
        .period_vld(period_vld),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every strobe must match the head of the expected queue in value and cycle.
    always @(negedge clk) begin
        if (period_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got period %0d at cycle %0d, expected no strobe",
                         period, cyc);
            end else begin
                mon_p = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                check("strobe_period", period, mon_p);
                check("strobe_cycle", cyc, mon_t);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
        check("wait_align", cyc, c);
    endtask

    // k is the clk edge at which pulse_in is first sampled high.
    task automatic send(input int width, input bit exp_vld, input int exp_per, output int k);
        k = cyc + 1;
        pulse_in = 1'b1;
        if (exp_vld) begin
            exp_q.push_back(CNT_W'(exp_per));
            exp_t_q.push_back(k + LAT);
        end
        repeat (width) step();
        pulse_in = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, output int k);
        send(v.width, v.exp_vld, v.exp_period, k);
        idle(v.gap);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pulse_in = 1'b0;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_vld"}, period_vld, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k, kl, k2, k3, k4;

        for (int i = 0; i < 5; i++) train_v[i] = '{1, 9, (i > 0), 10};
        min_v[0] = '{7, 1, 1'b0, 0};
        min_v[1] = '{1, 1, 1'b1, 8};
        for (int i = 2; i < 7; i++) min_v[i] = '{1, 1, 1'b1, 2};

        // 1. reset with toggling input
        rst = 1'b1;
        pulse_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("reset");
            pulse_in = ~pulse_in;
        end
        rst = 1'b0;
        pulse_in = 1'b0;
        idle(6);
        check_idle_outputs("post_reset");

        // 2. steady train, 10-cycle spacing
        for (int i = 0; i < 5; i++) begin
            run_vec(train_v[i], k);
            if (i == 0) check("train_unlocked_first", locked, 0);
        end
        check("train_locked", locked, 1);
        check("train_period", period, 10);
        check("train_timeout", timeout, 0);

        // 3. timeout after a 20-cycle train, recovery and a 15-cycle period
        do_reset(2);
        send(1, 1'b0, 0, k);
        idle(19);
        send(1, 1'b1, 20, k);
        idle(19);
        send(1, 1'b1, 20, kl);
        wait_cyc(kl + 2 + TMO);
        check("tmo_before_timeout", timeout, 0);
        check("tmo_before_locked", locked, 1);
        wait_cyc(kl + 3 + TMO);
        check("tmo_timeout", timeout, 1);
        check("tmo_locked", locked, 0);
        check("tmo_period_hold", period, 20);
        step();
        send(1, 1'b0, 0, k);
        wait_cyc(k + 2);
        check("tmo_sticky", timeout, 1);
        wait_cyc(k + 3);
        check("tmo_cleared", timeout, 0);
        check("tmo_period_still", period, 20);
        step();
        idle_until(k + 14);
        send(1, 1'b1, 15, k2);
        idle(5);
        check("tmo_relock", locked, 1);
        check("tmo_new_period", period, 15);

        // 4. boundary: spacing of exactly TIMEOUT, then TIMEOUT+1
        do_reset(2);
        send(1, 1'b0, 0, k);
        idle(TMO - 1);
        send(1, 1'b1, TMO, k);
        idle(TMO - 1);
        send(1, 1'b1, TMO, k3);
        idle_until(k3 + TMO);
        send(1, 1'b0, 0, k4);
        check("bnd_k4_spacing", k4 - k3, TMO + 1);
        wait_cyc(k3 + 2 + TMO);
        check("bnd_no_timeout", timeout, 0);
        check("bnd_period", period, TMO);
        check("bnd_locked", locked, 1);
        wait_cyc(k3 + 3 + TMO);
        check("bnd_timeout", timeout, 1);
        check("bnd_unlocked", locked, 0);
        wait_cyc(k4 + 3);
        check("bnd_timeout_cleared", timeout, 0);
        check("bnd_still_unlocked", locked, 0);
        check("bnd_period_hold", period, TMO);
        step();

        // 5. wide pulse followed by minimum-spacing pulses
        do_reset(2);
        for (int i = 0; i < 7; i++) run_vec(min_v[i], k);
        idle(6);
        check("min_locked", locked, 1);
        check("min_period", period, 2);

        // 6. reset in the middle of a 10-cycle measurement
        do_reset(2);
        send(1, 1'b0, 0, k);
        idle(9);
        send(1, 1'b1, 10, k2);
        idle_until(k2 + 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midrst");
        idle_until(k2 + 9);
        send(1, 1'b0, 0, k3);
        idle_until(k3 + 9);
        send(1, 1'b1, 10, k4);
        idle(6);
        check("midrst_period", period, 10);
        check("midrst_locked", locked, 1);

        idle(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
